// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs one request/ack bus transaction per memory
// op, stalls the pipeline until it completes, formats load data and raises
// misalignment / bus-timeout exception pulses.
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        excp_misalign_o,
    output logic        excp_bus_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    // Access sizes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    rdata_r;
    logic           err_r;

    logic           is_load;
    logic           is_store;
    logic           sext;
    logic [1:0]     size;
    logic           misalign;
    logic           mem_valid;
    logic [1:0]     lane;

    // Extract and extend the addressed byte/half from a captured bus word.
    function automatic logic [31:0] load_format(input logic [31:0] word,
                                                input logic [1:0]  a,
                                                input logic [1:0]  sz,
                                                input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[8*a +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_B:    res = {{24{sx & b[7]}}, b};
            SZ_H:    res = {{16{sx & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign lane = mem_addr_i[1:0];

    // Decode the memory-op descriptor into kind, size and extension.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        size     = SZ_W;
        case (mem_op_i)
            4'd1:    begin is_load  = 1'b1; size = SZ_B; sext = 1'b1; end
            4'd2:    begin is_load  = 1'b1; size = SZ_H; sext = 1'b1; end
            4'd3:    begin is_load  = 1'b1; size = SZ_W; end
            4'd4:    begin is_load  = 1'b1; size = SZ_B; end
            4'd5:    begin is_load  = 1'b1; size = SZ_H; end
            4'd6:    begin is_store = 1'b1; size = SZ_B; end
            4'd7:    begin is_store = 1'b1; size = SZ_H; end
            4'd8:    begin is_store = 1'b1; size = SZ_W; end
            default: begin is_load  = 1'b0; is_store = 1'b0; end
        endcase
        if (size == SZ_H) begin
            misalign = (is_load | is_store) & lane[0];
        end else if (size == SZ_W) begin
            misalign = (is_load | is_store) & (lane != 2'b00);
        end else begin
            misalign = 1'b0;
        end
        mem_valid = (is_load | is_store) & ~misalign;
    end

    // Access FSM: issue request, count wait cycles, capture data or time out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus_req_o       <= 1'b0;
            cnt             <= '0;
            rdata_r         <= 32'd0;
            err_r           <= 1'b0;
            excp_misalign_o <= 1'b0;
            excp_bus_o      <= 1'b0;
        end else begin
            excp_misalign_o <= 1'b0;
            excp_bus_o      <= 1'b0;
            case (state)
                IDLE: begin
                    excp_misalign_o <= misalign;
                    if (mem_valid) begin
                        state     <= WAIT;
                        bus_req_o <= 1'b1;
                        cnt       <= '0;
                        err_r     <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus_ack_i) begin
                        rdata_r   <= bus_rdata_i;
                        bus_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus_req_o  <= 1'b0;
                        excp_bus_o <= 1'b1;
                        err_r      <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Result, stall and bus-lane outputs; all forced low while in reset.
    always_comb begin
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        stallreq    = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = 32'd0;
        bus_sel_o   = 4'd0;
        bus_wdata_o = 32'd0;
        if (rst) begin
            wd_o = 5'd0;
        end else begin
            wd_o     = wd_i;
            stallreq = mem_valid & (state != DONE);
            if (is_load & mem_valid) begin
                // Load result is only meaningful once the data has been captured
                if (state == DONE) begin
                    wreg_o  = wreg_i & ~err_r;
                    wdata_o = load_format(rdata_r, lane, size, sext);
                end else begin
                    wreg_o  = 1'b0;
                    wdata_o = 32'd0;
                end
            end else begin
                wreg_o  = wreg_i & ~misalign;
                wdata_o = wdata_i;
            end
            if (mem_valid) begin
                bus_we_o   = is_store;
                bus_addr_o = {mem_addr_i[31:2], 2'b00};
                case (size)
                    SZ_B:    bus_sel_o = 4'b0001 << lane;
                    SZ_H:    bus_sel_o = 4'b0011 << lane;
                    default: bus_sel_o = 4'b1111;
                endcase
                if (is_store) begin
                    case (size)
                        SZ_B:    bus_wdata_o = {4{mem_wdata_i[7:0]}};
                        SZ_H:    bus_wdata_o = {2{mem_wdata_i[15:0]}};
                        default: bus_wdata_o = mem_wdata_i;
                    endcase
                end else begin
                    bus_wdata_o = 32'd0;
                end
            end else begin
                bus_we_o = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu with hand-computed expected values.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        excp_misalign_o;
    logic        excp_bus_o;

    int pass_cnt;
    int total_cnt;
    int stalls;
    int reqs;

    mem_lsu #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .excp_misalign_o(excp_misalign_o), .excp_bus_o(excp_bus_o)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        mem_op_i = 4'd0;
        tick();
    endtask

    // Present a memory op and run it to DONE; ack in WAIT cycle ack_after (-1 = never).
    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] st,
                          input int ack_after, input logic [31:0] rd,
                          output int n_stall, output int n_req);
        int widx;
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_wdata_i = st;
        wd_i        = 5'd7;
        wreg_i      = 1'b1;
        wdata_i     = 32'hCAFE_0000;
        #1;
        n_stall = 0;
        n_req   = 0;
        widx    = 0;
        for (int i = 0; i < 40 && stallreq; i++) begin
            n_stall++;
            if (bus_req_o) begin
                n_req++;
                if (widx == ack_after) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = rd;
                end
                widx++;
            end
            tick();
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'd0;
        end
        check("stall_release", {31'd0, stallreq}, 32'd0);
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst         = 1'b1;
        wd_i        = 5'd3;
        wreg_i      = 1'b1;
        wdata_i     = 32'h1111_2222;
        mem_op_i    = 4'd3;
        mem_addr_i  = 32'h0000_0100;
        mem_wdata_i = 32'h5555_5555;
        bus_rdata_i = 32'd0;
        bus_ack_i   = 1'b0;
        #3;
        check("rst_wd",      {27'd0, wd_o}, 32'd0);
        check("rst_wreg",    {31'd0, wreg_o}, 32'd0);
        check("rst_stall",   {31'd0, stallreq}, 32'd0);
        check("rst_req",     {31'd0, bus_req_o}, 32'd0);
        check("rst_addr",    bus_addr_o, 32'd0);
        check("rst_sel",     {28'd0, bus_sel_o}, 32'd0);
        mem_op_i = 4'd0;
        #9;
        rst = 1'b0;
        tick();

        // Non-memory pass-through
        mem_op_i = 4'd0; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        #1;
        check("pt_wd",    {27'd0, wd_o}, 32'd5);
        check("pt_wreg",  {31'd0, wreg_o}, 32'd1);
        check("pt_wdata", wdata_o, 32'hDEAD_BEEF);
        check("pt_stall", {31'd0, stallreq}, 32'd0);
        tick();
        check("pt_req",   {31'd0, bus_req_o}, 32'd0);

        // LW with ack in the third WAIT cycle
        access(4'd3, 32'h0000_0100, 32'd0, 2, 32'h1234_5678, stalls, reqs);
        check("lw_stalls", stalls, 32'd4);
        check("lw_wdata",  wdata_o, 32'h1234_5678);
        check("lw_wreg",   {31'd0, wreg_o}, 32'd1);
        check("lw_sel",    {28'd0, bus_sel_o}, 32'hF);
        check("lw_we",     {31'd0, bus_we_o}, 32'd0);
        go_idle();

        // LB / LBU at lane 3, immediate ack
        access(4'd1, 32'h0000_0103, 32'd0, 0, 32'h8011_2233, stalls, reqs);
        check("lb_stalls", stalls, 32'd2);
        check("lb_wdata",  wdata_o, 32'hFFFF_FF80);
        check("lb_sel",    {28'd0, bus_sel_o}, 32'h8);
        go_idle();
        access(4'd4, 32'h0000_0103, 32'd0, 0, 32'h8011_2233, stalls, reqs);
        check("lbu_wdata", wdata_o, 32'h0000_0080);
        go_idle();

        // LHU / LH upper half
        access(4'd5, 32'h0000_0102, 32'd0, 0, 32'hBEEF_1234, stalls, reqs);
        check("lhu_wdata", wdata_o, 32'h0000_BEEF);
        check("lhu_sel",   {28'd0, bus_sel_o}, 32'hC);
        go_idle();
        access(4'd2, 32'h0000_0102, 32'd0, 0, 32'hBEEF_1234, stalls, reqs);
        check("lh_wdata",  wdata_o, 32'hFFFF_BEEF);
        go_idle();

        // SB lane 1
        access(4'd6, 32'h0000_0101, 32'h0000_00AB, 0, 32'd0, stalls, reqs);
        check("sb_we",    {31'd0, bus_we_o}, 32'd1);
        check("sb_sel",   {28'd0, bus_sel_o}, 32'h2);
        check("sb_wdata", bus_wdata_o, 32'hABAB_ABAB);
        check("sb_addr",  bus_addr_o, 32'h0000_0100);
        check("sb_wdo",   wdata_o, 32'hCAFE_0000);
        go_idle();

        // SH lane 2
        access(4'd7, 32'h0000_0012, 32'h0000_C3D4, 0, 32'd0, stalls, reqs);
        check("sh_sel",   {28'd0, bus_sel_o}, 32'hC);
        check("sh_wdata", bus_wdata_o, 32'hC3D4_C3D4);
        go_idle();

        // Misaligned LW
        mem_op_i = 4'd3; mem_addr_i = 32'h0000_0102; wreg_i = 1'b1;
        #1;
        check("mis_stall", {31'd0, stallreq}, 32'd0);
        check("mis_wreg",  {31'd0, wreg_o}, 32'd0);
        tick();
        check("mis_pulse", {31'd0, excp_misalign_o}, 32'd1);
        check("mis_req",   {31'd0, bus_req_o}, 32'd0);
        mem_op_i = 4'd0;
        tick();
        check("mis_pulse_end", {31'd0, excp_misalign_o}, 32'd0);
        check("mis_req2",      {31'd0, bus_req_o}, 32'd0);

        // SW timeout
        access(4'd8, 32'h0000_0200, 32'h0102_0304, -1, 32'd0, stalls, reqs);
        check("to_reqs",   reqs, 32'd16);
        check("to_stalls", stalls, 32'd17);
        check("to_pulse",  {31'd0, excp_bus_o}, 32'd1);
        check("to_req_lo", {31'd0, bus_req_o}, 32'd0);
        go_idle();
        check("to_pulse_end", {31'd0, excp_bus_o}, 32'd0);

        // Timed-out load drops wreg
        access(4'd3, 32'h0000_0300, 32'd0, -1, 32'd0, stalls, reqs);
        check("tol_wreg", {31'd0, wreg_o}, 32'd0);
        go_idle();

        // Reset in the second WAIT cycle
        mem_op_i = 4'd3; mem_addr_i = 32'h0000_0200; wreg_i = 1'b1;
        #1;
        tick();
        tick();
        check("rw_req_before", {31'd0, bus_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("rw_req",   {31'd0, bus_req_o}, 32'd0);
        check("rw_stall", {31'd0, stallreq}, 32'd0);
        tick();
        check("rw_excp",  {30'd0, excp_bus_o, excp_misalign_o}, 32'd0);
        mem_op_i = 4'd0;
        #2;
        rst = 1'b0;
        tick();
        access(4'd3, 32'h0000_0204, 32'd0, 0, 32'hA5A5_0F0F, stalls, reqs);
        check("rw_lw_stalls", stalls, 32'd2);
        check("rw_lw_wdata",  wdata_o, 32'hA5A5_0F0F);
        check("rw_lw_wreg",   {31'd0, wreg_o}, 32'd1);
        go_idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit of the five-stage RISC-V pipeline. It sits directly downstream of the EX stage, behind the EX/MEM register.
- Takes the EX result (wd, wreg, wdata) plus the memory-op descriptor and runs a request/ack data-bus transaction.
- Aligns and sign/zero-extends load data; builds byte selects and store data.
- Holds the pipeline via stallreq until the access completes, then forwards the result to MEM/WB.

Parameters:
- TIMEOUT, 16, max cycles to wait for bus_ack_i before aborting the access (must be >= 1).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- wd_i  in  5  destination register address from EX/MEM
- wreg_i  in  1  register write enable from EX/MEM
- wdata_i  in  32  EX result
- mem_op_i  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- mem_addr_i  in  32  effective address (EX sum)
- mem_wdata_i  in  32  store data (rs2)
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stallreq  out  1  stall request to pipeline control
- bus_req_o  out  1  bus request (registered)
- bus_we_o  out  1  1 = store
- bus_addr_o  out  32  word-aligned address {mem_addr_i[31:2],2'b00}
- bus_sel_o  out  4  byte-lane enables
- bus_wdata_o  out  32  store data, lane-replicated
- bus_rdata_i  in  32  read data, valid with ack
- bus_ack_i  in  1  transaction complete
- excp_misalign_o  out  1  one-cycle pulse: misaligned access
- excp_bus_o  out  1  one-cycle pulse: bus timeout

Behaviour:
- Reset (rst=1, async): state IDLE, bus_req_o 0, timeout counter 0, rdata register 0, excp_* 0. Combinational outputs wd_o, wreg_o, wdata_o, stallreq, bus_we_o, bus_sel_o, bus_wdata_o, bus_addr_o are forced to 0.
- Upstream inputs are held stable while stallreq=1 (pipeline control guarantees this).
- Non-memory op: pass-through. wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stallreq=0, no bus activity.
- Misalignment: half-word ops with addr[0]=1; word ops with addr[1:0]!=0.
  - No request is issued; stallreq=0; wreg_o forced 0.
  - excp_misalign_o=1 registered on the next edge, for one cycle.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if an aligned memory op is present, stallreq=1; on the next edge go to WAIT, set bus_req_o=1, clear the counter.
  - WAIT: stallreq=1, bus_req_o=1, address/sel/we/wdata stable, counter increments each cycle.
    - On bus_ack_i=1: capture bus_rdata_i, bus_req_o=0 next edge, go to DONE.
    - If ack has not arrived and the counter reaches TIMEOUT-1: bus_req_o=0, excp_bus_o pulses one cycle, go to DONE with the capture flagged as errored.
  - DONE: stallreq=0 and the result is presented; the pipeline advances at the edge; go to IDLE unconditionally.
- Ack outside WAIT is ignored.
- Latency: ack in the first WAIT cycle gives 3 cycles per access (IDLE, WAIT, DONE). Each extra wait cycle adds 1.
- A back-to-back memory op arriving after DONE starts from IDLE; there is no bubble beyond the FSM.
- Load result, with lane a = mem_addr_i[1:0], little-endian:
  - LB: sign-extend byte a. LBU: zero-extend byte a.
  - LH: sign-extend half a[1]. LHU: zero-extend half a[1].
  - LW: full word.
  - wdata_o=formatted data and wreg_o=wreg_i, in DONE only.
  - Errored load: wreg_o=0.
- Store:
  - bus_we_o=1.
  - SB: sel=4'b0001<<a, wdata={4{rs2[7:0]}}.
  - SH: sel=4'b0011<<a, wdata={2{rs2[15:0]}}.
  - SW: sel=4'b1111, wdata=rs2.
  - wd_o/wreg_o/wdata_o pass through from the inputs.
- Loads: bus_we_o=0, bus_wdata_o=0, sel per access size (same as the store encoding).
- Reset mid-WAIT: bus_req_o drops immediately (async), state IDLE, the transaction is discarded, no exception pulse.

Test Plan:
- LW addr 0x0000_0100, ack two cycles after bus_req_o rises, rdata 0x1234_5678 -> stallreq high 4 cycles, wdata_o=0x1234_5678 in DONE with wreg_o=1, bus_sel_o=4'b1111.
- LB addr 0x0000_0103, rdata 0x8011_2233, immediate ack -> 3-cycle access, wdata_o=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- LHU addr 0x0000_0102, rdata 0xBEEF_1234 -> wdata_o=0x0000_BEEF. Same with LH -> 0xFFFF_BEEF.
- SB addr 0x0000_0101, rs2 0x0000_00AB -> bus_we_o=1, bus_sel_o=4'b0010, bus_wdata_o=0xABAB_ABAB, bus_addr_o=0x0000_0100.
- LW addr 0x0000_0102 -> bus_req_o never rises, stallreq=0, wreg_o=0, excp_misalign_o one-cycle pulse.
- SW with no ack, TIMEOUT=16 -> bus_req_o high exactly 16 cycles, excp_bus_o pulses once, stallreq then drops.
- Assert rst in the 2nd WAIT cycle -> bus_req_o=0 immediately, no excp pulse; the next LW after reset completes normally.
